div_seq_ctrl: RTL and testbench
===============================

# div_seq_ctrl

Sequencing controller for the 4-bit calculator's divider datapath. It takes the three raw active-low push-buttons and runs operand entry for the numerator and denominator. It then issues a one-cycle start to the divider, waits for its done pulse, and captures quotient and remainder. Finally it steps the LED display through the results. It replaces the free-running 2-bit selector, adds divide-by-zero and divider-timeout protection, and sits between the board buttons/LEDs and the divider.

## Interface
Parameters:
- `W`, 4, operand/result width
- `TO_W`, 6, timeout counter width; RUN aborts after 2^TO_W cycles without done
- `BLINK_W`, 3, error-blink counter width; LEDs toggle every 2^BLINK_W cycles

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `up`  in  1  raw button, active-low (0 = pressed), asynchronous to clk
- `down`  in  1  raw button, active-low
- `ok`  in  1  raw button, active-low
- `div_a`  out  W  numerator to divider; equals the num register
- `div_b`  out  W  denominator to divider; equals the den register
- `div_start`  out  1  one-cycle start pulse to divider
- `div_done`  in  1  one-cycle completion pulse from divider
- `div_q`  in  W  quotient; valid in the div_done cycle
- `div_r`  in  W  remainder; valid in the div_done cycle
- `leds`  out  W  display value
- `phase`  out  3  state code, for debug and indicator LEDs
- `err`  out  1  high while in ERR

## Operation
- **Button input**
  - Each button passes through a 2-flop synchronizer, reset to 1 (released).
  - A press is a 1→0 transition of the synchronized signal; there is one press event per physical press, no auto-repeat.
  - Priority within a cycle: ok > up/down.
  - If up and down press in the same cycle, both are ignored.
- **States (phase code)**
  - **NUM (0)**
    - up: num = num+1 mod 2^W. down: num = num−1 mod 2^W.
    - ok → DEN.
    - leds = num.
  - **DEN (1)**
    - up/down edit den with the same wrap rules.
    - ok with den==0 → ERR; no div_start is issued.
    - ok with den≠0 → RUN.
    - leds = den.
  - **RUN (2)**
    - div_start = 1 in exactly the first RUN cycle.
    - num and den are frozen; all buttons are ignored.
    - leds = 0.
    - On div_done: q_reg ← div_q, r_reg ← div_r, → QUO.
    - Timeout counter clears on RUN entry and increments each RUN cycle. When it reaches 2^TO_W−1 with no div_done → ERR.
    - div_done in the same cycle as timeout: done wins.
  - **QUO (3)**
    - leds = q_reg.
    - ok → REM.
  - **REM (4)**
    - leds = r_reg.
    - ok → NUM; num and den are retained for re-edit.
  - **ERR (5)**
    - err = 1.
    - leds alternate all-ones/all-zeros; the blink counter clears on ERR entry, starting at all-ones.
    - ok → NUM; num and den are retained.
  - **Illegal codes (6, 7)** → NUM on the next edge.
- div_done outside RUN is ignored.
- In every state except NUM/DEN, up/down presses are ignored.

## Timing
- **Reset values:** phase=0 (NUM), num=den=q_reg=r_reg=0, leds=0, div_start=0, err=0, timeout and blink counters 0, synchronizer flops 1.
- Asynchronous assertion; deassertion is taken on the next clk edge.
- **Press latency:** pin low before edge k → synchronized low at edge k+1 → state/register update at edge k+2.
- leds, err and phase are combinational decodes of registered state, with no extra latency.
- div_start is registered and asserted in the cycle after the DEN ok edge, i.e. the first RUN cycle.
- div_a/div_b are stable from that cycle until RUN exits.
- Capture happens on the edge ending the div_done cycle; QUO is visible in the next cycle.
- **Reset mid-RUN:** returns to NUM with zeroed operands and drops div_start. The divider result is discarded and a later div_done is ignored.

## Test plan
- **Reset:** hold rst=0 with buttons released → phase=0, leds=0000, div_start=0, err=0; release → no state change without presses.
- **Normal divide:**
  - Stimulus: 13 up presses, ok, 4 up presses, ok; model divider returns done 5 cycles after start with q=3, r=1.
  - Required response: exactly one div_start pulse with div_a=13, div_b=4; leds=0011 in QUO; after ok, leds=0001 in REM; after ok, phase=0 with leds=1101.
- **Wrap and simultaneity:**
  - In NUM from 0, one down press → leds=1111; then up → 0000.
  - up and down pressed in the same cycle → value unchanged.
- **Divide by zero:**
  - Stimulus: num=7, den=0, ok.
  - Required response: phase=5, err=1; leds alternate 1111/0000 every 8 cycles; div_start never asserts; ok → phase=0 with num=7 retained.
- **Timeout:**
  - Stimulus: num=9, den=2, ok; div_done held 0.
  - Required response: ERR exactly 64 cycles after RUN entry.
  - Repeat with div_done on cycle 63 → QUO, not ERR.
- **Reset mid-RUN:** assert rst during RUN, then pulse div_done after release → phase=0, leds=0000, q_reg/r_reg unchanged at 0.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Sequencing controller for the 4-bit calculator divider: button entry of
// numerator/denominator, start/done handshake, result display, error handling.
module div_seq_ctrl #(
    parameter int W       = 4,
    parameter int TO_W    = 6,
    parameter int BLINK_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up,
    input  logic         down,
    input  logic         ok,
    output logic [W-1:0] div_a,
    output logic [W-1:0] div_b,
    output logic         div_start,
    input  logic         div_done,
    input  logic [W-1:0] div_q,
    input  logic [W-1:0] div_r,
    output logic [W-1:0] leds,
    output logic [2:0]   phase,
    output logic         err
);

    typedef enum logic [2:0] {
        ST_NUM = 3'd0,
        ST_DEN = 3'd1,
        ST_RUN = 3'd2,
        ST_QUO = 3'd3,
        ST_REM = 3'd4,
        ST_ERR = 3'd5
    } state_t;

    localparam logic [W-1:0]       ZERO_W    = {W{1'b0}};
    localparam logic [W-1:0]       ONE_W     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]       ALL1_W    = {W{1'b1}};
    localparam logic [TO_W-1:0]    TO_ZERO   = {TO_W{1'b0}};
    localparam logic [TO_W-1:0]    TO_ONE    = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]    TO_MAX    = {TO_W{1'b1}};
    localparam logic [BLINK_W-1:0] BL_ZERO   = {BLINK_W{1'b0}};
    localparam logic [BLINK_W-1:0] BL_ONE    = {{(BLINK_W-1){1'b0}}, 1'b1};
    localparam logic [BLINK_W-1:0] BL_MAX    = {BLINK_W{1'b1}};

    // Modular increment/decrement of an operand; inc and dec are mutually exclusive.
    function automatic logic [W-1:0] step_val(input logic [W-1:0] v,
                                              input logic inc,
                                              input logic dec);
        logic [W-1:0] res;
        if (inc) begin
            res = v + ONE_W;
        end else if (dec) begin
            res = v - ONE_W;
        end else begin
            res = v;
        end
        return res;
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic               start_nx_s;
    logic [2:0]         sync1_r;
    logic [2:0]         sync2_r;
    logic [2:0]         prev_r;
    logic [2:0]         press_s;
    logic               ok_press_s;
    logic               up_press_s;
    logic               dn_press_s;
    logic [W-1:0]       num_r;
    logic [W-1:0]       den_r;
    logic [W-1:0]       q_r;
    logic [W-1:0]       r_r;
    logic [TO_W-1:0]    to_cnt_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               blink_on_r;
    logic               div_start_r;

    // Button synchronizers plus a delayed copy for falling-edge press detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 3'b111;
            sync2_r <= 3'b111;
            prev_r  <= 3'b111;
        end else begin
            sync1_r <= {ok, down, up};
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Press events; ok has priority, simultaneous up+down cancel each other.
    always_comb begin
        press_s    = prev_r & ~sync2_r;
        ok_press_s = press_s[2];
        up_press_s = press_s[0] & ~press_s[1] & ~press_s[2];
        dn_press_s = press_s[1] & ~press_s[0] & ~press_s[2];
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_NUM;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode and start request.
    always_comb begin
        state_nx_s = ST_NUM;
        start_nx_s = 1'b0;
        case (state_r)
            ST_NUM: begin
                if (ok_press_s) begin
                    state_nx_s = ST_DEN;
                end else begin
                    state_nx_s = ST_NUM;
                end
            end
            ST_DEN: begin
                if (ok_press_s) begin
                    if (den_r == ZERO_W) begin
                        state_nx_s = ST_ERR;
                    end else begin
                        state_nx_s = ST_RUN;
                        start_nx_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_DEN;
                end
            end
            ST_RUN: begin
                // A done arriving in the final timeout cycle still completes the divide.
                if (div_done) begin
                    state_nx_s = ST_QUO;
                end else if (to_cnt_r == TO_MAX) begin
                    state_nx_s = ST_ERR;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_QUO: begin
                if (ok_press_s) begin
                    state_nx_s = ST_REM;
                end else begin
                    state_nx_s = ST_QUO;
                end
            end
            ST_REM: begin
                if (ok_press_s) begin
                    state_nx_s = ST_NUM;
                end else begin
                    state_nx_s = ST_REM;
                end
            end
            ST_ERR: begin
                if (ok_press_s) begin
                    state_nx_s = ST_NUM;
                end else begin
                    state_nx_s = ST_ERR;
                end
            end
            default: begin
                state_nx_s = ST_NUM;
            end
        endcase
    end

    // Operand registers, edited only in their own entry state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_r <= ZERO_W;
            den_r <= ZERO_W;
        end else begin
            if ((state_r == ST_NUM) && !ok_press_s) begin
                num_r <= step_val(num_r, up_press_s, dn_press_s);
            end else begin
                num_r <= num_r;
            end
            if ((state_r == ST_DEN) && !ok_press_s) begin
                den_r <= step_val(den_r, up_press_s, dn_press_s);
            end else begin
                den_r <= den_r;
            end
        end
    end

    // Result capture, start pulse and RUN timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r         <= ZERO_W;
            r_r         <= ZERO_W;
            to_cnt_r    <= TO_ZERO;
            div_start_r <= 1'b0;
        end else begin
            div_start_r <= start_nx_s;
            if ((state_r == ST_RUN) && div_done) begin
                q_r <= div_q;
                r_r <= div_r;
            end else begin
                q_r <= q_r;
                r_r <= r_r;
            end
            if (state_r == ST_RUN) begin
                to_cnt_r <= to_cnt_r + TO_ONE;
            end else begin
                to_cnt_r <= TO_ZERO;
            end
        end
    end

    // Error blink: held at the all-ones phase outside ERR, toggles every 2^BLINK_W cycles inside.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_r <= BL_ZERO;
            blink_on_r  <= 1'b1;
        end else if (state_r == ST_ERR) begin
            blink_cnt_r <= blink_cnt_r + BL_ONE;
            if (blink_cnt_r == BL_MAX) begin
                blink_on_r <= ~blink_on_r;
            end else begin
                blink_on_r <= blink_on_r;
            end
        end else begin
            blink_cnt_r <= BL_ZERO;
            blink_on_r  <= 1'b1;
        end
    end

    // Display and status decode of registered state.
    always_comb begin
        leds = ZERO_W;
        err  = 1'b0;
        case (state_r)
            ST_NUM:  leds = num_r;
            ST_DEN:  leds = den_r;
            ST_RUN:  leds = ZERO_W;
            ST_QUO:  leds = q_r;
            ST_REM:  leds = r_r;
            ST_ERR: begin
                err = 1'b1;
                if (blink_on_r) begin
                    leds = ALL1_W;
                end else begin
                    leds = ZERO_W;
                end
            end
            default: leds = ZERO_W;
        endcase
    end

    assign phase     = state_r;
    assign div_a     = num_r;
    assign div_b     = den_r;
    assign div_start = div_start_r;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: button stimulus, model divider,
// scoreboard of expected start operands and divide results.
module tb_div_seq_ctrl;

    localparam int W = 4;
    localparam logic [2:0] B_UP = 3'b001;
    localparam logic [2:0] B_DN = 3'b010;
    localparam logic [2:0] B_OK = 3'b100;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         up = 1'b1, down = 1'b1, ok = 1'b1;
    logic [W-1:0] div_a, div_b, div_q = '0, div_r = '0, leds;
    logic         div_start, div_done = 1'b0, err;
    logic [2:0]   phase;

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;
    logic [7:0] start_q[$];
    logic [7:0] res_q[$];
    logic [7:0] cur_ab = 8'h00;
    logic [7:0] res;
    logic [W-1:0] num_m = '0, den_m = '0;
    logic         found;

    div_seq_ctrl #(.W(W), .TO_W(6), .BLINK_W(3)) dut (
        .clk(clk), .rst(rst), .up(up), .down(down), .ok(ok),
        .div_a(div_a), .div_b(div_b), .div_start(div_start),
        .div_done(div_done), .div_q(div_q), .div_r(div_r),
        .leds(leds), .phase(phase), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Scoreboard for start pulses and operand stability during RUN.
    always @(negedge clk) begin
        if (rst && div_start) begin
            n_starts++;
            if (start_q.size() == 0) begin
                check_eq("unexpected_start", 32'd1, 32'd0);
            end else begin
                cur_ab = start_q.pop_front();
                check_eq("start_a", div_a, cur_ab[7:4]);
                check_eq("start_b", div_b, cur_ab[3:0]);
            end
        end
        if (rst && phase == 3'd2) begin
            check_eq("run_a_stable", div_a, cur_ab[7:4]);
            check_eq("run_b_stable", div_b, cur_ab[3:0]);
        end
    end

    task automatic press_btn(input logic [2:0] m);
        @(posedge clk); #1;
        {ok, down, up} = ~m;
        repeat (3) @(posedge clk);
        #1;
        {ok, down, up} = 3'b111;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tap(input logic [2:0] m);
        press_btn(m);
        idle(3);
    endtask

    task automatic wait_start();
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (div_start) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("start_seen", found, 1'b1);
    endtask

    // Drives done during the cycle 'dly' cycles after the start cycle; called from its negedge.
    task automatic pulse_done(input int dly);
        logic [W-1:0] q, r;
        q = num_m / den_m;
        r = num_m % den_m;
        repeat (dly) @(posedge clk);
        #1;
        div_done = 1'b1; div_q = q; div_r = r;
        res_q.push_back({q, r});
        @(posedge clk); #1;
        div_done = 1'b0; div_q = 4'hA; div_r = 4'h5;
    endtask

    task automatic run_divide(input int dly);
        start_q.push_back({num_m, den_m});
        press_btn(B_OK);
        wait_start();
        pulse_done(dly);
        @(negedge clk);
        check_eq("quo_phase", phase, 3'd3);
        if (res_q.size() == 0) begin
            check_eq("res_queue_empty", 32'd1, 32'd0);
        end else begin
            res = res_q.pop_front();
            check_eq("quo_leds", leds, res[7:4]);
            idle(3);
            tap(B_OK);
            @(negedge clk);
            check_eq("rem_phase", phase, 3'd4);
            check_eq("rem_leds", leds, res[3:0]);
            tap(B_OK);
            @(negedge clk);
            check_eq("back_num_phase", phase, 3'd0);
            check_eq("back_num_leds", leds, num_m);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_phase", phase, 3'd0);
        check_eq("rst_leds", leds, 4'd0);
        check_eq("rst_start", div_start, 1'b0);
        check_eq("rst_err", err, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        idle(5);
        @(negedge clk);
        check_eq("idle_phase", phase, 3'd0);
        check_eq("idle_leds", leds, 4'd0);

        // Wrap and simultaneous presses
        tap(B_DN); num_m = num_m - 4'd1;
        @(negedge clk); check_eq("wrap_down", leds, 4'hF);
        tap(B_UP); num_m = num_m + 4'd1;
        @(negedge clk); check_eq("wrap_up", leds, 4'h0);
        tap(B_UP | B_DN);
        @(negedge clk); check_eq("up_dn_same", leds, 4'h0);

        // Normal divide 13 / 4
        for (int i = 0; i < 13; i++) begin
            tap(B_UP); num_m = num_m + 4'd1;
        end
        @(negedge clk); check_eq("num13", leds, 4'd13);
        tap(B_OK);
        @(negedge clk); check_eq("den_phase", phase, 3'd1);
        for (int i = 0; i < 4; i++) begin
            tap(B_UP); den_m = den_m + 4'd1;
        end
        @(negedge clk); check_eq("den4", leds, 4'd4);
        run_divide(5);
        check_eq("one_start", n_starts, 1);

        // Divide by zero: num=7, den=0
        for (int i = 0; i < 6; i++) begin
            tap(B_DN); num_m = num_m - 4'd1;
        end
        tap(B_OK);
        for (int i = 0; i < 4; i++) begin
            tap(B_DN); den_m = den_m - 4'd1;
        end
        @(negedge clk); check_eq("den0", leds, 4'd0);
        press_btn(B_OK);
        @(negedge clk);
        check_eq("dz_phase", phase, 3'd5);
        check_eq("dz_err", err, 1'b1);
        check_eq("blink_c0", leds, 4'hF);
        repeat (7) @(negedge clk); check_eq("blink_c7", leds, 4'hF);
        @(negedge clk);            check_eq("blink_c8", leds, 4'h0);
        repeat (7) @(negedge clk); check_eq("blink_c15", leds, 4'h0);
        @(negedge clk);            check_eq("blink_c16", leds, 4'hF);
        check_eq("dz_no_start", n_starts, 1);
        idle(1);
        tap(B_OK);
        @(negedge clk);
        check_eq("dz_ok_phase", phase, 3'd0);
        check_eq("dz_num_kept", leds, 4'd7);
        check_eq("dz_err_clear", err, 1'b0);

        // Timeout: num=9, den=2, no done
        for (int i = 0; i < 2; i++) begin
            tap(B_UP); num_m = num_m + 4'd1;
        end
        tap(B_OK);
        for (int i = 0; i < 2; i++) begin
            tap(B_UP); den_m = den_m + 4'd1;
        end
        start_q.push_back({num_m, den_m});
        press_btn(B_OK);
        wait_start();
        check_eq("run_leds", leds, 4'd0);
        repeat (63) @(negedge clk);
        check_eq("to_c63_run", phase, 3'd2);
        @(negedge clk);
        check_eq("to_c64_err", phase, 3'd5);
        check_eq("to_err", err, 1'b1);
        idle(1);
        tap(B_OK);
        @(negedge clk); check_eq("to_back_num", leds, 4'd9);

        // Done in the last timeout cycle wins
        tap(B_OK);
        @(negedge clk); check_eq("to2_den", leds, 4'd2);
        run_divide(63);
        check_eq("starts_after_to", n_starts, 3);

        // Reset mid-RUN
        tap(B_OK);
        start_q.push_back({num_m, den_m});
        press_btn(B_OK);
        wait_start();
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_phase", phase, 3'd0);
        check_eq("mid_rst_start", div_start, 1'b0);
        idle(2);
        rst = 1'b1;
        num_m = '0; den_m = '0;
        idle(2);
        div_done = 1'b1; div_q = 4'd5; div_r = 4'd3;
        @(posedge clk); #1 div_done = 1'b0;
        @(negedge clk);
        check_eq("late_done_phase", phase, 3'd0);
        check_eq("late_done_leds", leds, 4'd0);
        check_eq("late_done_a", div_a, 4'd0);
        check_eq("late_done_b", div_b, 4'd0);

        check_eq("start_q_drained", start_q.size(), 0);
        check_eq("total_starts", n_starts, 4);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
